// File: rtl/pipe_stage_ctrl_if.sv
// Handshake/bus bundle between the hazard/fetch side and the pipeline stage controller.
interface pipe_stage_ctrl_if;
  logic [31:0] instr_fetch;
  logic        stall;
  logic        calc_branch;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] instrIFID;
  logic [31:0] instrIDEX;
  logic [31:0] instrEXMEM;
  logic [31:0] instrMEMWB;
  logic        fetch_en;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        hazard_err;

  // Hazard unit / instruction memory side
  modport master (
    output instr_fetch, stall, calc_branch, br_taken, br_target,
    input  pc, instrIFID, instrIDEX, instrEXMEM, instrMEMWB,
    input  fetch_en, state, stall_cnt, flush_cnt, hazard_err
  );

  // Stage controller side
  modport slave (
    input  instr_fetch, stall, calc_branch, br_taken, br_target,
    output pc, instrIFID, instrIDEX, instrEXMEM, instrMEMWB,
    output fetch_en, state, stall_cnt, flush_cnt, hazard_err
  );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Five-stage pipeline controller: pc, per-stage instruction registers,
// stall/redirect sequencing, and stall/flush statistics.
module pipe_stage_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_ctrl_if.slave bus
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned FILL_W   = 3;
  localparam int unsigned CONS_W   = 4;
  localparam int unsigned FILL_CYC = 4;

  localparam logic [XLEN-1:0]   NOP       = '0;
  localparam logic [XLEN-1:0]   PC_STEP   = XLEN'(4);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYC - 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ifid_q, ifid_d;
  logic [XLEN-1:0]   idex_q, idex_d;
  logic [XLEN-1:0]   exmem_q, exmem_d;
  logic [XLEN-1:0]   memwb_q, memwb_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CONS_W-1:0] consec_q, consec_d;
  logic              err_q, err_d;

  logic in_fill;
  logic stall_eff;
  logic redir;

  // Hazard requests only take effect once the pipeline has filled; stall beats redirect
  assign in_fill   = (state_q == ST_FILL);
  assign stall_eff = bus.stall & ~in_fill;
  assign redir     = ~in_fill & ~bus.stall & bus.calc_branch & bus.br_taken;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      pc_q        <= '0;
      ifid_q      <= NOP;
      idex_q      <= NOP;
      exmem_q     <= NOP;
      memwb_q     <= NOP;
      fill_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      fill_q      <= fill_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
    end
  end

  // Next-state, pipeline movement and counters
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    idex_d      = idex_q;
    exmem_d     = idex_q;
    memwb_d     = exmem_q;
    fill_d      = fill_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = consec_q;
    err_d       = err_q;

    // Datapath: back half always drains; front half holds, squashes or advances
    if (stall_eff) begin
      idex_d = NOP;
    end else if (redir) begin
      pc_d   = bus.br_target;
      ifid_d = NOP;
      idex_d = ifid_q;
    end else begin
      pc_d   = pc_q + PC_STEP;
      ifid_d = bus.instr_fetch;
      idex_d = ifid_q;
    end

    // FSM: fixed-length fill, then the same transition rules from every other state
    if (in_fill) begin
      fill_d = fill_q + FILL_W'(1);
      if (fill_q == FILL_LAST) begin
        state_d = ST_RUN;
      end
    end else if (stall_eff) begin
      state_d = ST_STALL;
    end else if (redir) begin
      state_d = ST_REDIRECT;
    end else begin
      state_d = ST_RUN;
    end

    // Saturating statistics
    if (stall_eff && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (redir && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Runaway-stall detection; the flag is sticky until reset
    if (!bus.stall) begin
      consec_d = '0;
    end else if (!in_fill && (consec_q != CONS_MAX)) begin
      consec_d = consec_q + CONS_W'(1);
    end
    if (consec_d == CONS_MAX) begin
      err_d = 1'b1;
    end
  end

  // Fetch advances unless a stall is honoured
  assign bus.fetch_en = ~bus.stall | in_fill;

  assign bus.pc         = pc_q;
  assign bus.instrIFID  = ifid_q;
  assign bus.instrIDEX  = idex_q;
  assign bus.instrEXMEM = exmem_q;
  assign bus.instrMEMWB = memwb_q;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.hazard_err = err_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized and directed bench for pipe_stage_ctrl against a behavioural pipeline model.
module tb_pipe_stage_ctrl;

  logic clk;
  logic rst_n;

  pipe_stage_ctrl_if bus ();

  pipe_stage_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  // Behavioural model: stages[0]=IFID .. stages[3]=MEMWB
  logic [31:0] m_pc;
  logic [31:0] m_stg [4];
  int          m_state;   // 0 FILL, 1 RUN, 2 STALL, 3 REDIRECT
  int          m_fill_left;
  int          m_scnt;
  int          m_fcnt;
  int          m_run;     // consecutive honoured stall cycles
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_stg[i] = 0;
    m_state = 0;
    m_fill_left = 4;
    m_scnt = 0;
    m_fcnt = 0;
    m_run = 0;
    m_err = 0;
  endtask

  task automatic model_step(input bit st, input bit cb, input bit bt,
                            input logic [31:0] tgt, input logic [31:0] fetch);
    logic [31:0] old [4];
    bit filling;
    for (int i = 0; i < 4; i++) old[i] = m_stg[i];
    filling = (m_state == 0);
    m_stg[3] = old[2];
    m_stg[2] = old[1];
    if (!filling && st) begin
      m_stg[1] = 0;
      m_scnt = (m_scnt < 65535) ? m_scnt + 1 : m_scnt;
      m_state = 2;
    end else if (!filling && cb && bt) begin
      m_stg[1] = old[0];
      m_stg[0] = 0;
      m_pc = tgt;
      m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
      m_state = 3;
    end else begin
      m_stg[1] = old[0];
      m_stg[0] = fetch;
      m_pc = m_pc + 32'd4;
      if (filling) begin
        m_fill_left--;
        m_state = (m_fill_left == 0) ? 1 : 0;
      end else begin
        m_state = 1;
      end
    end
    if (!st) m_run = 0;
    else if (!filling && m_run < 15) m_run++;
    if (m_run == 15) m_err = 1;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_pc"},    bus.pc, m_pc);
    chk({pfx, "_ifid"},  bus.instrIFID, m_stg[0]);
    chk({pfx, "_idex"},  bus.instrIDEX, m_stg[1]);
    chk({pfx, "_exmem"}, bus.instrEXMEM, m_stg[2]);
    chk({pfx, "_memwb"}, bus.instrMEMWB, m_stg[3]);
    chk({pfx, "_state"}, 32'(bus.state), 32'(m_state));
    chk({pfx, "_scnt"},  32'(bus.stall_cnt), 32'(m_scnt));
    chk({pfx, "_fcnt"},  32'(bus.flush_cnt), 32'(m_fcnt));
    chk({pfx, "_err"},   32'(bus.hazard_err), 32'(m_err));
  endtask

  // One clock: drive inputs, check the combinational fetch enable, clock, check registers
  task automatic step(input string pfx, input bit st, input bit cb, input bit bt,
                      input logic [31:0] tgt, input logic [31:0] fetch);
    bus.stall       = st;
    bus.calc_branch = cb;
    bus.br_taken    = bt;
    bus.br_target   = tgt;
    bus.instr_fetch = fetch;
    #1;
    chk({pfx, "_fetch_en"}, 32'(bus.fetch_en), 32'(!st || m_state == 0));
    model_step(st, cb, bt, tgt, fetch);
    @(posedge clk);
    #1;
    check_all(pfx);
  endtask

  task automatic async_reset(input string pfx);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(pfx);
    chk({pfx, "_fetch_en"}, 32'(bus.fetch_en), 32'd1);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] IA = 32'h1111_0001;
  localparam logic [31:0] IB = 32'h2222_0002;
  localparam logic [31:0] IC = 32'h3333_0003;
  localparam logic [31:0] ID = 32'h4444_0004;
  localparam logic [31:0] IE = 32'h5555_0005;

  initial begin
    logic [31:0] x;
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.calc_branch = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.instr_fetch = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    rst_n = 1'b1;

    // Fill: hazard inputs ignored, pipeline loads A..D, RUN after 4 edges
    step("fill1", 1'b1, 1'b1, 1'b1, 32'h0000_0800, IA);
    chk("fill1_pc_const", bus.pc, 32'd4);
    step("fill2", 1'b0, 1'b0, 1'b0, 32'h0, IB);
    step("fill3", 1'b1, 1'b0, 1'b0, 32'h0, IC);
    step("fill4", 1'b0, 1'b0, 1'b0, 32'h0, ID);
    chk("fill_memwb_const", bus.instrMEMWB, IA);
    chk("fill_exmem_const", bus.instrEXMEM, IB);
    chk("fill_idex_const",  bus.instrIDEX, IC);
    chk("fill_ifid_const",  bus.instrIFID, ID);
    chk("fill_state_const", 32'(bus.state), 32'd1);
    chk("fill_pc16_const",  bus.pc, 32'd16);
    step("run1", 1'b0, 1'b0, 1'b0, 32'h0, IE);
    chk("run1_pc_const", bus.pc, 32'd20);

    // Two-cycle stall
    x = bus.instrIFID;
    step("stl1", 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_0001);
    step("stl2", 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_0002);
    chk("stl_ifid_hold", bus.instrIFID, x);
    chk("stl_idex_nop", bus.instrIDEX, 32'h0);
    chk("stl_scnt_const", 32'(bus.stall_cnt), 32'd2);
    chk("stl_pc_hold", bus.pc, 32'd20);
    step("stl3", 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_0003);
    chk("stl_run_const", 32'(bus.state), 32'd1);

    // Taken redirect, then not-taken, then conflicting stall+redirect
    step("br1", 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hBAD0_0000);
    chk("br_pc_const", bus.pc, 32'h100);
    chk("br_ifid_nop", bus.instrIFID, 32'h0);
    chk("br_fcnt_const", 32'(bus.flush_cnt), 32'd1);
    chk("br_state_const", 32'(bus.state), 32'd3);
    step("br2", 1'b0, 1'b1, 1'b0, 32'h0000_0900, 32'h0A0A_0A0A);
    step("br3", 1'b0, 1'b0, 1'b1, 32'h0000_0900, 32'h0B0B_0B0B);
    step("cfl", 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0C0C_0C0C);
    chk("cfl_pc_const", bus.pc, 32'h108);
    chk("cfl_fcnt_const", 32'(bus.flush_cnt), 32'd1);
    chk("cfl_state_const", 32'(bus.state), 32'd2);
    step("cfl2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0D0D_0D0D);
    chk("cfl2_state_const", 32'(bus.state), 32'd3);
    step("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0E0E_0E0E);
    chk("wrap_pc_const", bus.pc, 32'h0);

    // Runaway stall: error on the 15th consecutive stalled edge, sticky afterwards
    for (int i = 1; i <= 15; i++) begin
      step("hz", 1'b1, 1'b0, 1'b0, 32'h0, 32'(i));
      if (i == 14) chk("hz14_err_const", 32'(bus.hazard_err), 32'd0);
    end
    chk("hz15_err_const", 32'(bus.hazard_err), 32'd1);
    step("hz_drop", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0F0F_0F0F);
    chk("hz_sticky_const", 32'(bus.hazard_err), 32'd1);

    // Reset in the middle of a stall, then refill from pc 0
    step("pre_rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h1);
    step("pre_rst2", 1'b1, 1'b1, 1'b1, 32'h40, 32'h2);
    async_reset("mrst");
    step("post_rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h7777_7777);
    chk("post_rst_pc_const", bus.pc, 32'd4);
    chk("post_rst_state_const", 32'(bus.state), 32'd0);

    // Random traffic with occasional stall bursts and resets
    for (int c = 0; c < 500; c++) begin
      bit st, cb, bt;
      st = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 49) == 0) begin
        for (int k = 0; k < int'($urandom_range(10, 18)); k++)
          step("rnd_burst", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFF_FFFC, $urandom);
      end
      cb = ($urandom_range(0, 99) < 30);
      bt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      step("rnd", st, cb, bt, $urandom & 32'hFFFF_FFFC, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low: clk input 1 (rising-edge clock), rst_n input 1 (asynchronous active-low reset).
REQ-002 Input `instr_fetch` (32 bits) SHALL carry the instruction word read from instruction memory at address `pc`.
REQ-003 Input `stall` (1 bit) SHALL be the hazard-unit load-use/branch-operand stall request.
REQ-004 Input `calc_branch` (1 bit) SHALL be the hazard-unit request to resolve the control-flow instruction in IF/ID.
REQ-005 Inputs `br_taken` (1 bit) and `br_target` (32 bits) SHALL give the ID-stage branch/jump/jr outcome and destination.
REQ-006 Output `pc` (32 bits) SHALL be the fetch address.
REQ-007 Outputs `instrIFID`, `instrIDEX`, `instrEXMEM` and `instrMEMWB` (32 bits each) SHALL be the per-stage instruction words consumed by the forwarding/hazard unit.
REQ-008 Output `fetch_en` (1 bit) SHALL be high when instruction memory must advance.
REQ-009 Output `state` (2 bits) SHALL report FSM state: FILL=0, RUN=1, STALL=2, REDIRECT=3.
REQ-010 Output `stall_cnt` (16 bits) SHALL count cycles spent in STALL, saturating at 0xFFFF.
REQ-011 Output `flush_cnt` (16 bits) SHALL count taken redirects, saturating at 0xFFFF.
REQ-012 Output `hazard_err` (1 bit) SHALL be a sticky flag for a runaway stall.

Function
REQ-013 NOP SHALL be 32'h00000000 (op 0, funct 0); all squashed or bubbled slots SHALL load NOP.
REQ-014 Normal advance SHALL work as follows: pc<=pc+4 with modulo 2^32 wrap, IFID<=instr_fetch, IDEX<=IFID, EXMEM<=IDEX, MEMWB<=EXMEM.
REQ-015 When `stall`=1, pc and IFID SHALL hold, IDEX SHALL load NOP, EXMEM/MEMWB SHALL advance, and fetch_en SHALL be 0.
REQ-016 When `calc_branch`=1 and `br_taken`=1 with `stall`=0, pc SHALL load br_target, IFID SHALL load NOP (squash the wrong-path fetch), IDEX<=IFID, and later stages SHALL advance.
REQ-017 When `calc_branch`=1 and `br_taken`=0, the block SHALL perform normal advance.
REQ-018 When `stall` and `calc_branch` are asserted together, stall SHALL win and the redirect SHALL be ignored that cycle (no pc load, no flush_cnt increment).
REQ-019 `br_taken` and `br_target` SHALL be ignored when `calc_branch`=0.
REQ-020 In FILL, the block SHALL enter after reset and remain for 4 cycles (3-bit fill counter); the pipeline SHALL advance normally but stall and calc_branch SHALL be ignored; it SHALL then go to RUN.
REQ-021 In RUN, `stall` SHALL move the FSM to STALL, and a taken redirect SHALL move it to REDIRECT; otherwise it SHALL stay in RUN.
REQ-022 In STALL, the FSM SHALL stay while `stall`=1; when stall drops it SHALL go to REDIRECT if a taken redirect is present that cycle, else to RUN.
REQ-023 REDIRECT SHALL be a one-cycle state marking the first cycle of fetch from the new target; it SHALL then go to STALL, REDIRECT or RUN by the same rules as RUN.
REQ-024 `stall_cnt` SHALL increment on every clock edge where `stall`=1 outside FILL.
REQ-025 `flush_cnt` SHALL increment on every accepted taken redirect.
REQ-026 A 4-bit consecutive-stall counter SHALL clear whenever `stall`=0.
REQ-027 When the consecutive-stall counter reaches 15, `hazard_err` SHALL set and stay set until reset; the pipeline SHALL continue to obey `stall`.
REQ-028 All outputs SHALL be registered except `fetch_en`, which SHALL be combinational: ~stall OR (state==FILL).

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously hold: pc=0, all four instr registers=NOP, state=FILL, fill counter=0, stall_cnt=0, flush_cnt=0, consecutive counter=0, hazard_err=0.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard pending work immediately; the first edge after release SHALL be FILL cycle 1 with pc advancing 0->4.

Verification
REQ-031 Reset release, instr_fetch=A,B,C,D,E per cycle -> pc 4,8,12,16,20; after 4 edges MEMWB=A, EXMEM=B, IDEX=C, IFID=D; state goes FILL->RUN after 4 cycles.
REQ-032 In RUN with IFID=X and stall=1 for 2 cycles -> pc held, IFID=X both cycles, IDEX=NOP, stall_cnt=2, state STALL then RUN.
REQ-033 calc_branch=1, br_taken=1, br_target=0x00000100 -> next pc=0x100, IFID=NOP, flush_cnt=1, state=REDIRECT for 1 cycle.
REQ-034 stall=1 and calc_branch=1/br_taken=1 in the same cycle -> pc held, flush_cnt unchanged, state=STALL.
REQ-035 stall held 15 cycles -> hazard_err=1 at the 15th edge and still 1 after stall drops; stall_cnt=15.
REQ-036 pc=0xFFFFFFFC with normal advance -> pc=0x00000000; rst_n pulsed low mid-stall -> all outputs at reset values within the same cycle.
